uart_burst_rx: RTL

UART_BURST_RX -- requirements
Module: uart_burst_rx

---
 rtl/uart_burst_rx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_burst_rx.sv
// 8N1 serial receiver that delivers each byte (normal mode) or packs four bytes
// LSB-first into one 32-bit word (burst mode). Optional macro: RX_BURST_TIMEOUT_EN.
module uart_burst_rx #(
    parameter int BAUDBITS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [31:0] d,
    input  logic        wrbaud,
    input  logic        rd,
    output logic [31:0] q,
    output logic        dv,
    output logic        fe,
    output logic        ove,
    output logic [1:0]  nbytes,
    output logic        tmo
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    logic [1:0]          sync_reg;
    logic                rxd_prev_reg;
    logic [BAUDBITS-1:0] div_reg;
    logic [BAUDBITS-1:0] baud_cnt_reg;
    logic                mode_reg;
    rx_state_t           state_reg;
    logic [2:0]          bit_idx_reg;
    logic [7:0]          shift_reg;
    logic [23:0]         asm_reg;
    logic                asm_err_reg;
    logic [1:0]          nbytes_reg;
    logic [31:0]         q_reg;
    logic                dv_reg;
    logic                fe_reg;
    logic                ove_reg;

    logic       rxd_s;
    logic       rxd_edge;
    logic       rxd_fall;
    logic       tick;
    logic       byte_done;
    logic       byte_err;
    logic       deliver;
    logic       tmo_fire;
    logic [2:0] lane_sel;
    logic       unused_d;

    assign rxd_s     = sync_reg[1];
    assign rxd_edge  = rxd_s ^ rxd_prev_reg;
    assign rxd_fall  = rxd_prev_reg & ~rxd_s;
    assign tick      = (baud_cnt_reg == (div_reg >> 1));
    assign byte_done = (state_reg == STOP) && tick;
    assign byte_err  = ~rxd_s;
    assign deliver   = byte_done && (!mode_reg || nbytes_reg == 2'd3);
    assign unused_d  = ^d[30:BAUDBITS];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane_sel
            assign lane_sel[gi] = (nbytes_reg == 2'(gi));
        end
    endgenerate

    // Synchronizer, edge history and the free-running bit divider (re-phased by every edge).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg     <= 2'b11;
            rxd_prev_reg <= 1'b1;
            baud_cnt_reg <= '0;
        end else begin
            sync_reg     <= {sync_reg[0], rxd};
            rxd_prev_reg <= rxd_s;
            if (rxd_edge || baud_cnt_reg == '0)
                baud_cnt_reg <= div_reg;
            else
                baud_cnt_reg <= baud_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg  <= '0;
            mode_reg <= 1'b0;
        end else if (wrbaud) begin
            div_reg  <= d[BAUDBITS-1:0];
            mode_reg <= d[31];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rxd_fall)
                        state_reg <= START;
                end
                START: begin
                    if (tick) begin
                        bit_idx_reg <= 3'd0;
                        state_reg   <= rxd_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg   <= {rxd_s, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7)
                            state_reg <= STOP;
                    end
                end
                STOP: begin
                    if (tick)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Burst assembly: the fourth byte never lands in asm_reg, it goes straight to q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_reg     <= 24'h0;
            asm_err_reg <= 1'b0;
            nbytes_reg  <= 2'd0;
        end else if (wrbaud || tmo_fire) begin
            asm_err_reg <= 1'b0;
            nbytes_reg  <= 2'd0;
        end else if (byte_done && mode_reg) begin
            nbytes_reg  <= nbytes_reg + 2'd1;
            asm_err_reg <= (nbytes_reg == 2'd3) ? 1'b0 : (asm_err_reg | byte_err);
            for (int i = 0; i < 3; i++)
                if (lane_sel[i])
                    asm_reg[8*i +: 8] <= shift_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg   <= 32'h0;
            dv_reg  <= 1'b0;
            fe_reg  <= 1'b0;
            ove_reg <= 1'b0;
        end else if (deliver) begin
            q_reg  <= mode_reg ? {shift_reg, asm_reg} : {24'h0, shift_reg};
            fe_reg <= byte_err | (mode_reg & asm_err_reg);
            dv_reg <= 1'b1;
            if (rd)
                ove_reg <= 1'b0;
            else if (dv_reg)
                ove_reg <= 1'b1;
        end else if (rd) begin
            dv_reg  <= 1'b0;
            ove_reg <= 1'b0;
        end
    end

`ifdef RX_BURST_TIMEOUT_EN
    logic [3:0] tmo_cnt_reg;
    logic       tmo_arm_reg;
    logic       tmo_reg;

    // Counts mid-bit ticks after the last stop sample, so the 16th tick is 16 bit periods later.
    assign tmo_fire = tmo_arm_reg && tick && tmo_cnt_reg == 4'd15 && mode_reg && nbytes_reg != 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_reg <= 4'd0;
            tmo_arm_reg <= 1'b0;
            tmo_reg     <= 1'b0;
        end else begin
            tmo_reg <= tmo_fire;
            if (byte_done) begin
                tmo_arm_reg <= 1'b1;
                tmo_cnt_reg <= 4'd0;
            end else if (wrbaud || tmo_fire || (state_reg == IDLE && rxd_fall)) begin
                tmo_arm_reg <= 1'b0;
            end else if (tmo_arm_reg && tick) begin
                tmo_cnt_reg <= tmo_cnt_reg + 4'd1;
            end
        end
    end

    assign tmo = tmo_reg;
`else
    assign tmo_fire = 1'b0;
    assign tmo      = 1'b0;
`endif

    assign q      = q_reg;
    assign dv     = dv_reg;
    assign fe     = fe_reg;
    assign ove    = ove_reg;
    assign nbytes = nbytes_reg;

endmodule
